// File: rtl/sbus_sram_bridge_if.sv
// Bus bundle between an sbus master, the bridge, and an SRAM-like split-handshake slave.
// The slave modport is the bridge's view. The master modport is the surrounding environment's view.
interface sbus_sram_bridge_if;
  logic        s_en;
  logic        s_we;
  logic [1:0]  s_size;
  logic [31:0] s_addr;
  logic [31:0] s_data_w;
  logic [31:0] s_data_r;
  logic        s_stall;
  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;

  modport slave (
    input  s_en, s_we, s_size, s_addr, s_data_w, m_addr_ok, m_data_ok, m_rdata,
    output s_data_r, s_stall, m_req, m_wr, m_size, m_addr, m_wdata
  );

  modport master (
    output s_en, s_we, s_size, s_addr, s_data_w, m_addr_ok, m_data_ok, m_rdata,
    input  s_data_r, s_stall, m_req, m_wr, m_size, m_addr, m_wdata
  );
endinterface

// File: rtl/sbus_sram_bridge.sv
// sbus slave endpoint: turns each sbus access into one req/addr_ok/data_ok transaction
// and stalls the master until the data phase completes.
module sbus_sram_bridge (
  input  logic                clk,
  input  logic                rst_n,
  sbus_sram_bridge_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        orphan_q, orphan_d;
  logic        drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      orphan_q <= orphan_d;
    end
  end

  // A master that drops s_en in the completing cycle is treated as already flushed.
  assign drop = orphan_q | ~bus.s_en;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    orphan_d = orphan_q;
    unique case (state_q)
      IDLE: begin
        if (bus.s_en) begin
          we_d     = bus.s_we;
          size_d   = bus.s_size;
          addr_d   = bus.s_addr;
          wdata_d  = bus.s_data_w;
          orphan_d = 1'b0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (!bus.s_en) orphan_d = 1'b1;
        if (bus.m_addr_ok) begin
          if (bus.m_data_ok) begin
            if (!drop && !we_q) rdata_d = bus.m_rdata;
            state_d = drop ? IDLE : DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!bus.s_en) orphan_d = 1'b1;
        if (bus.m_data_ok) begin
          if (!drop && !we_q) rdata_d = bus.m_rdata;
          state_d = drop ? IDLE : DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_stall  = bus.s_en & (state_q != DONE);
  assign bus.s_data_r = rdata_q;
  assign bus.m_req    = (state_q == REQ);
  assign bus.m_wr     = we_q;
  assign bus.m_size   = size_q;
  assign bus.m_addr   = addr_q;
  assign bus.m_wdata  = wdata_q;

endmodule

// File: tb/tb_sbus_sram_bridge.sv
// Directed per-cycle vectors for sbus_sram_bridge plus a hand-written async-reset sequence.
module tb_sbus_sram_bridge;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  sbus_sram_bridge_if bus ();

  sbus_sram_bridge dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        en, we;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    logic        aok, dok;
    logic [31:0] rd;
    logic        xst, xrq, cm, xwr;
    logic [1:0]  xsz;
    logic [31:0] xa, xwd, xsdr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic en, input logic we, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input logic aok, input logic dok,
                     input logic [31:0] rd, input logic xst, input logic xrq, input logic cm,
                     input logic xwr, input logic [1:0] xsz, input logic [31:0] xa,
                     input logic [31:0] xwd, input logic [31:0] xsdr);
    vec_t v;
    v.nm = nm; v.en = en; v.we = we; v.sz = sz; v.a = a; v.wd = wd;
    v.aok = aok; v.dok = dok; v.rd = rd; v.xst = xst; v.xrq = xrq; v.cm = cm;
    v.xwr = xwr; v.xsz = xsz; v.xa = xa; v.xwd = xwd; v.xsdr = xsdr;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic aok, input logic dok, input logic [31:0] rd);
    bus.s_en = en; bus.s_we = we; bus.s_size = sz; bus.s_addr = a; bus.s_data_w = wd;
    bus.m_addr_ok = aok; bus.m_data_ok = dok; bus.m_rdata = rd;
  endtask

  task automatic run_row(input vec_t v);
    drive(v.en, v.we, v.sz, v.a, v.wd, v.aok, v.dok, v.rd);
    @(negedge clk);
    check({v.nm, ".stall"}, {31'd0, bus.s_stall}, {31'd0, v.xst});
    check({v.nm, ".req"},   {31'd0, bus.m_req},   {31'd0, v.xrq});
    check({v.nm, ".sdr"},   bus.s_data_r,         v.xsdr);
    if (v.cm) begin
      check({v.nm, ".wr"},    {31'd0, bus.m_wr},   {31'd0, v.xwr});
      check({v.nm, ".size"},  {30'd0, bus.m_size}, {30'd0, v.xsz});
      check({v.nm, ".addr"},  bus.m_addr,          v.xa);
      check({v.nm, ".wdata"}, bus.m_wdata,         v.xwd);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;

    //   name    en we sz  addr          wdata         aok dok rdata        st rq cm wr sz  addr          wdata         s_data_r
    // Read, fast slave
    add("t1c0", 1, 0, 2, 32'h1FC00000, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0);
    add("t1c1", 1, 0, 2, 32'h1FC00000, 32'h0,        1, 1, 32'h3C1DBFC0, 1, 1, 1, 0, 2, 32'h1FC00000, 32'h0,        32'h0);
    add("t1c2", 1, 0, 2, 32'h1FC00000, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h3C1DBFC0);
    add("t1c3", 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h3C1DBFC0);
    // Write, split phases
    add("t2c0", 1, 1, 2, 32'h80001004, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h3C1DBFC0);
    add("t2c1", 1, 1, 2, 32'h80001004, 32'hDEADBEEF, 0, 0, 32'h0,        1, 1, 1, 1, 2, 32'h80001004, 32'hDEADBEEF, 32'h3C1DBFC0);
    add("t2c2", 1, 1, 2, 32'h80001004, 32'hDEADBEEF, 0, 0, 32'h0,        1, 1, 1, 1, 2, 32'h80001004, 32'hDEADBEEF, 32'h3C1DBFC0);
    add("t2c3", 1, 1, 2, 32'h80001004, 32'hDEADBEEF, 1, 0, 32'h0,        1, 1, 1, 1, 2, 32'h80001004, 32'hDEADBEEF, 32'h3C1DBFC0);
    add("t2c4", 1, 1, 2, 32'h80001004, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h3C1DBFC0);
    add("t2c5", 1, 1, 2, 32'h80001004, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h3C1DBFC0);
    add("t2c6", 1, 1, 2, 32'h80001004, 32'hDEADBEEF, 0, 1, 32'h12345678, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h3C1DBFC0);
    add("t2c7", 1, 1, 2, 32'h80001004, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h3C1DBFC0);
    add("t2c8", 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h3C1DBFC0);
    // Back-to-back reads, zero-wait slave
    add("t3c0", 1, 0, 2, 32'h100,      32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h3C1DBFC0);
    add("t3c1", 1, 0, 2, 32'h100,      32'h0,        1, 1, 32'h11111111, 1, 1, 1, 0, 2, 32'h100,      32'h0,        32'h3C1DBFC0);
    add("t3c2", 1, 0, 2, 32'h100,      32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h11111111);
    add("t3c3", 1, 0, 2, 32'h104,      32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h11111111);
    add("t3c4", 1, 0, 2, 32'h104,      32'h0,        1, 1, 32'h22222222, 1, 1, 1, 0, 2, 32'h104,      32'h0,        32'h11111111);
    add("t3c5", 1, 0, 2, 32'h104,      32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h22222222);
    add("t3c6", 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h22222222);
    // Byte size pass-through
    add("t6c0", 1, 0, 0, 32'h80000003, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h22222222);
    add("t6c1", 1, 0, 0, 32'h80000003, 32'h0,        1, 0, 32'h0,        1, 1, 1, 0, 0, 32'h80000003, 32'h0,        32'h22222222);
    add("t6c2", 1, 0, 0, 32'h80000003, 32'h0,        0, 1, 32'h000000AB, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h22222222);
    add("t6c3", 1, 0, 0, 32'h80000003, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h000000AB);
    add("t6c4", 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h000000AB);
    // Flush: s_en drops in WAIT, new read of 0x300 waits out the orphan
    add("t4c0", 1, 0, 2, 32'h200,      32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h000000AB);
    add("t4c1", 1, 0, 2, 32'h200,      32'h0,        1, 0, 32'h0,        1, 1, 1, 0, 2, 32'h200,      32'h0,        32'h000000AB);
    add("t4c2", 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h000000AB);
    add("t4c3", 1, 0, 2, 32'h300,      32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h000000AB);
    add("t4c4", 1, 0, 2, 32'h300,      32'h0,        0, 1, 32'hAAAA0000, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h000000AB);
    add("t4c5", 1, 0, 2, 32'h300,      32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h000000AB);
    add("t4c6", 1, 0, 2, 32'h300,      32'h0,        1, 1, 32'h33330000, 1, 1, 1, 0, 2, 32'h300,      32'h0,        32'h000000AB);
    add("t4c7", 1, 0, 2, 32'h300,      32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h33330000);
    add("t4c8", 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h33330000);

    // Reset state
    rst_n = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    #2;
    check("rst.stall0", {31'd0, bus.s_stall}, 32'd0);
    check("rst.req",    {31'd0, bus.m_req},   32'd0);
    check("rst.wr",     {31'd0, bus.m_wr},    32'd0);
    check("rst.size",   {30'd0, bus.m_size},  32'd0);
    check("rst.addr",   bus.m_addr,           32'd0);
    check("rst.wdata",  bus.m_wdata,          32'd0);
    check("rst.sdr",    bus.s_data_r,         32'd0);
    bus.s_en = 1'b1;
    #1;
    check("rst.stall1", {31'd0, bus.s_stall}, 32'd1);
    bus.s_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int unsigned i = 0; i < vq.size(); i++) run_row(vq[i]);

    // Async reset in the middle of a REQ phase
    drive(1, 1, 1, 32'h400, 32'h5555, 0, 0, 32'h0);
    @(negedge clk);
    check("t5.idle_stall", {31'd0, bus.s_stall}, 32'd1);
    check("t5.idle_req",   {31'd0, bus.m_req},   32'd0);
    @(posedge clk);
    #1;
    check("t5.req_high",   {31'd0, bus.m_req},   32'd1);
    check("t5.req_addr",   bus.m_addr,           32'h400);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5.req_drop",   {31'd0, bus.m_req},   32'd0);
    check("t5.wr",         {31'd0, bus.m_wr},    32'd0);
    check("t5.size",       {30'd0, bus.m_size},  32'd0);
    check("t5.addr",       bus.m_addr,           32'd0);
    check("t5.wdata",      bus.m_wdata,          32'd0);
    check("t5.sdr",        bus.s_data_r,         32'd0);
    check("t5.stall_en",   {31'd0, bus.s_stall}, 32'd1);
    bus.s_en = 1'b0;
    #1;
    check("t5.stall_noen", {31'd0, bus.s_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'hDEAD0000);
    @(negedge clk);
    check("t5.stray_req",  {31'd0, bus.m_req},   32'd0);
    check("t5.stray_sdr",  bus.s_data_r,         32'd0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    check("t5.after_req",   {31'd0, bus.m_req},   32'd0);
    check("t5.after_stall", {31'd0, bus.s_stall}, 32'd0);
    check("t5.after_sdr",   bus.s_data_r,         32'd0);
    bus.s_en = 1'b1;
    #1;
    check("t5.after_idle_stall", {31'd0, bus.s_stall}, 32'd1);
    @(posedge clk);
    #1;
    check("t5.fresh_req",  {31'd0, bus.m_req},   32'd1);
    bus.s_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sbus_sram_bridge.md
Name: sbus_sram_bridge

Overview:
Slave-side endpoint of the core's sbus. It converts each sbus access into one transaction on an SRAM-like split-handshake port (req/addr_ok/data_ok). It holds the pipeline with stall until the external data phase completes. One instance each sits below the instruction fetch stage and the memory stage, feeding the external memory/AXI adapter.

Parameters:
None.

Ports:
clk        input   1   system clock, all state on rising edge
rst_n      input   1   asynchronous active-low reset
s_en       input   1   sbus request valid (held by master while stall=1)
s_we       input   1   sbus write (1) / read (0)
s_size     input   2   sbus access size: 0=byte, 1=half, 2=word
s_addr     input   32  sbus byte address
s_data_w   input   32  sbus write data
s_data_r   output  32  sbus read data, valid in the cycle stall falls with s_en=1
s_stall    output  1   sbus stall (combinational)
m_req      output  1   SRAM-like request valid
m_wr       output  1   SRAM-like write
m_size     output  2   SRAM-like size, copy of latched s_size
m_addr     output  32  SRAM-like address, copy of latched s_addr
m_wdata    output  32  SRAM-like write data, copy of latched s_data_w
m_addr_ok  input   1   address phase accepted
m_data_ok  input   1   data phase complete (read data valid / write done)
m_rdata    input   32  read data, valid with m_data_ok

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: state=IDLE, orphan=0. Latched request registers are 0. s_data_r=0, m_req=0, m_wr=0, m_size=0, m_addr=0, m_wdata=0. s_stall=s_en.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On s_en=1, latch s_we/s_size/s_addr/s_data_w and clear orphan, then go to REQ.
  - m_req=0.
  - m_addr_ok and m_data_ok are ignored.
- REQ:
  - m_req=1, with m_* driven from the latched registers, never directly from s_*.
  - On m_addr_ok=1 with m_data_ok=1 in the same cycle, capture m_rdata and go to DONE (IDLE if orphan).
  - On m_addr_ok=1 with m_data_ok=0, go to WAIT.
  - m_data_ok without m_addr_ok is ignored (protocol violation).
  - m_req stays high until addr_ok.
- WAIT:
  - m_req=0.
  - On m_data_ok=1, capture m_rdata into s_data_r (reads only; writes leave s_data_r unchanged), then go to DONE, or IDLE if orphan.
- DONE:
  - s_stall=0 for exactly one cycle.
  - Next state is always IDLE.
  - A new s_en seen in the following IDLE cycle starts the next transaction.
- s_stall = s_en & (state != DONE).
- Minimum read latency with addr_ok and data_ok both in REQ: stall high 2 cycles (IDLE, REQ), low in DONE, so 3 cycles per access. Back-to-back accesses: 3 cycles each minimum.
- Orphan (flush):
  - If s_en=0 in any cycle while state is REQ or WAIT, set orphan.
  - An external transaction already issued is never aborted. It runs to data_ok, the result is discarded, and the FSM returns to IDLE without entering DONE.
  - A new s_en during an orphaned transaction sees stall=1 until the bridge returns to IDLE and re-latches.
- s_en changing s_addr while stall=1 and not orphaned is a master error; the bridge uses the latched values.
- Async reset mid-transaction:
  - Immediate IDLE, m_req drops combinationally.
  - Any later data_ok from the slave is ignored in IDLE.
- Width rules:
  - Sizes and addresses pass through unchanged; no alignment checks (done upstream).
  - s_data_r is the raw 32-bit m_rdata word; byte/half extraction is the master's job.

Test Plan:
1. Read, fast slave: s_en=1, s_we=0, s_addr=0x1FC00000. Slave gives addr_ok+data_ok in the first REQ cycle with m_rdata=0x3C1DBFC0.
   Required: m_req high 1 cycle, stall high 2 cycles, and s_data_r=0x3C1DBFC0 in the stall-low cycle.
2. Write, split phases: s_we=1, s_size=2, s_addr=0x80001004, s_data_w=0xDEADBEEF. addr_ok comes after 2 cycles of req, data_ok 3 cycles later.
   Required: m_wr=1, m_addr=0x80001004, m_wdata=0xDEADBEEF held through REQ; stall low exactly once after data_ok; s_data_r unchanged.
3. Back-to-back: two reads to 0x100 and 0x104 with a zero-wait slave.
   Required: m_addr sequence 0x100 then 0x104; each read 3 cycles; no duplicate m_req for 0x100.
4. Flush: read 0x200 issued; s_en drops in WAIT; master presents a read of 0x300 before data_ok (return 0xAAAA0000).
   Required: stall stays 1; 0xAAAA0000 is never presented; a fresh m_req for 0x300 follows and its data is returned.
5. Reset mid-op: rst_n low during REQ.
   Required: m_req=0 immediately, all outputs at reset values; a stray data_ok after reset release causes no state change.
6. Byte size pass-through: s_size=0, s_addr=0x80000003.
   Required: m_size=0, m_addr=0x80000003 unchanged.
